// File: rtl/ppe_rr_pipe.sv
// Two-stage programmable priority encoder with a round-robin start pointer.
// S1 registers the request beat; the wrapped search runs between S1 and S2.
module ppe_rr_pipe #(
    parameter int W  = 512,
    parameter int LW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  Req,
    input  logic [LW-1:0] P_enc,
    input  logic          rr_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] o_value,
    output logic          found,
    output logic [LW-1:0] rr_ptr
);

    logic          s1_valid;
    logic [W-1:0]  s1_req;
    logic [LW-1:0] s1_penc;
    logic          s1_rr;

    logic          s2_adv;
    logic [LW-1:0] start;
    logic [W-1:0]  masked;
    logic [W-1:0]  pick_src;
    logic [W-1:0]  pick_oh;
    logic [LW-1:0] grant;
    logic          any;

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !rst && (!s1_valid || s2_adv);

    // Start index is resolved at transfer time so back-to-back RR beats see the fresh pointer.
    always_comb begin
        start    = s1_rr ? rr_ptr : s1_penc;
        masked   = s1_req & ({W{1'b1}} << start);
        pick_src = (|masked) ? masked : s1_req;
        pick_oh  = pick_src & (-pick_src);
        any      = |s1_req;
        grant    = '0;
        for (int i = 0; i < W; i++) begin
            if (pick_oh[i]) begin
                grant = grant | LW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_req    <= '0;
            s1_penc   <= '0;
            s1_rr     <= 1'b0;
            out_valid <= 1'b0;
            o_value   <= '0;
            found     <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_req   <= Req;
                s1_penc  <= P_enc;
                s1_rr    <= rr_mode;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                out_valid <= 1'b1;
                o_value   <= grant;
                found     <= any;
                // W is a power of two, so the LW-bit increment wraps W-1 to 0.
                if (s1_rr && any) begin
                    rr_ptr <= grant + LW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ppe_rr_pipe.sv
// Bench for ppe_rr_pipe: directed scenarios plus random traffic checked against
// an in-order reference model that searches the request vector with wrap.
module tb_ppe_rr_pipe;
    localparam int W  = 512;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, rr_mode, out_valid, out_ready, found;
    logic [W-1:0]  Req;
    logic [LW-1:0] P_enc, o_value, rr_ptr;

    logic       v8, rdy8, rr8, ov8, or8, f8;
    logic [7:0] req8;
    logic [2:0] penc8, val8, ptr8;

    always #5 clk = ~clk;

    ppe_rr_pipe #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Req(Req), .P_enc(P_enc), .rr_mode(rr_mode), .out_valid(out_valid),
        .out_ready(out_ready), .o_value(o_value), .found(found), .rr_ptr(rr_ptr)
    );

    ppe_rr_pipe #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
        .Req(req8), .P_enc(penc8), .rr_mode(rr8), .out_valid(ov8),
        .out_ready(or8), .o_value(val8), .found(f8), .rr_ptr(ptr8)
    );

    typedef struct {
        logic [W-1:0] req;
        int           penc;
        bit           rr;
    } beat_t;

    beat_t         mq[$];
    int            mptr;
    int            got_q[$];
    int            ptr_q[$];
    int            n_chk, n_fail;
    bit            hold_pending;
    logic [LW-1:0] held_v;
    logic          held_f;
    logic          ir_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input int act[$], input int exp[$]);
        chk({tag, "_count"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk(tag, act[i], exp[i]);
    endtask

    // Lowest set index at or above s, wrapping; -1 when nothing is set.
    function automatic int ref_enc(logic [W-1:0] r, int s, int w);
        for (int k = 0; k < w; k++) begin
            int idx;
            idx = (s + k) % w;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Called at a falling edge: drive, observe handshakes, advance one cycle.
    task automatic step(input logic v, input logic [W-1:0] req, input logic [LW-1:0] penc,
                        input bit rr, input bit ordy);
        beat_t b;
        int    s, g;
        in_valid = v; Req = req; P_enc = penc; rr_mode = rr; out_ready = ordy;
        #1;
        ir_seen = in_ready;
        if (hold_pending) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_value", o_value, held_v);
            chk("hold_found", found, held_f);
        end
        hold_pending = out_valid && !out_ready && !rst;
        held_v = o_value;
        held_f = found;
        if (out_valid && out_ready && !rst) begin
            if (mq.size() == 0) begin
                chk("out_without_beat", out_valid, 0);
            end else begin
                b = mq.pop_front();
                s = b.rr ? mptr : b.penc;
                g = ref_enc(b.req, s, W);
                chk("o_value", o_value, (g < 0) ? 0 : g);
                chk("found", found, (g >= 0) ? 1 : 0);
                if (b.rr && g >= 0) mptr = (g + 1) % W;
                chk("rr_ptr", rr_ptr, mptr);
                got_q.push_back(int'(o_value));
                ptr_q.push_back(int'(rr_ptr));
            end
        end
        if (in_valid && in_ready) begin
            b.req = req; b.penc = int'(penc); b.rr = rr;
            mq.push_back(b);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        hold_pending = 1'b0;
        repeat (n) step(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        mq.delete();
        mptr = 0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] req_a, req_b, req_c, r;
        int           e1[$], e2[$];
        int           nxt;
        int           g8[$], p8[$];

        n_chk = 0; n_fail = 0; mptr = 0; hold_pending = 1'b0;
        in_valid = 0; Req = '0; P_enc = '0; rr_mode = 0; out_ready = 0;
        v8 = 0; req8 = '0; penc8 = '0; rr8 = 0; or8 = 0;
        rst = 1'b1;
        @(negedge clk);
        do_reset(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_o_value", o_value, 0);
        chk("rst_found", found, 0);
        chk("rst_rr_ptr", rr_ptr, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Programmable mode, wrap and empty request
        req_a = '0; req_a[3] = 1'b1; req_a[100] = 1'b1; req_a[400] = 1'b1;
        got_q.delete(); ptr_q.delete();
        step(1'b1, req_a, 9'd101, 1'b0, 1'b1);
        chk("lat_s1_out_valid", out_valid, 0);
        step(1'b1, req_a, 9'd400, 1'b0, 1'b1);
        chk("lat_s2_out_valid", out_valid, 1);
        step(1'b1, req_a, 9'd401, 1'b0, 1'b1);
        step(1'b1, '0, 9'd5, 1'b0, 1'b1);
        drain(4);
        e1 = '{400, 400, 3, 0};
        chk_seq("prog_grants", got_q, e1);
        chk("prog_rr_ptr", rr_ptr, 0);

        // Round-robin back-to-back
        req_b = '0; req_b[5] = 1'b1; req_b[9] = 1'b1; req_b[511] = 1'b1;
        got_q.delete(); ptr_q.delete();
        repeat (4) step(1'b1, req_b, 9'd0, 1'b1, 1'b1);
        drain(4);
        e1 = '{5, 9, 511, 5};
        e2 = '{6, 10, 0, 6};
        chk_seq("rr_grants", got_q, e1);
        chk_seq("rr_ptrs", ptr_q, e2);

        // Backpressure with out_ready low for cycles 3..5
        got_q.delete(); ptr_q.delete();
        nxt = 0;
        for (int c = 0; c < 30; c++) begin
            logic v;
            v = (nxt < 6);
            step(v, '1, LW'(nxt), 1'b0, !(c >= 3 && c <= 5));
            if (c == 4) chk("bp_in_ready", ir_seen, 0);
            if (v && ir_seen) nxt++;
        end
        e1 = '{0, 1, 2, 3, 4, 5};
        chk_seq("bp_order", got_q, e1);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            r = '0;
            case ($urandom % 4)
                0: repeat ($urandom_range(0, 3)) r[$urandom % W] = 1'b1;
                1: for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
                2: r[$urandom % W] = 1'b1;
                default: r = '1;
            endcase
            step(($urandom % 4) != 0, r, LW'($urandom % W), bit'($urandom % 2), ($urandom % 4) != 0);
        end
        drain(6);
        chk("rand_drain", mq.size(), 0);

        // Reset with both stages full in round-robin mode
        req_c = '0; req_c[7] = 1'b1;
        step(1'b1, req_c, 9'd0, 1'b1, 1'b0);
        step(1'b1, req_c, 9'd0, 1'b1, 1'b0);
        chk("pre_rst_rr_ptr", rr_ptr, 8);
        do_reset(1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_rr_ptr", rr_ptr, 0);
        chk("mid_rst_o_value", o_value, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        got_q.delete(); ptr_q.delete();
        step(1'b1, req_c, 9'd0, 1'b1, 1'b1);
        drain(3);
        e1 = '{7};
        e2 = '{8};
        chk_seq("post_rst_grant", got_q, e1);
        chk_seq("post_rst_ptr", ptr_q, e2);

        // W=8 instance alternating round-robin grants
        for (int c = 0; c < 10; c++) begin
            v8 = (c < 4); req8 = 8'b1000_0001; rr8 = 1'b1; or8 = 1'b1; penc8 = 3'd3;
            #1;
            if (ov8 && or8) begin
                g8.push_back(int'(val8));
                p8.push_back(int'(ptr8));
            end
            @(negedge clk);
        end
        e1 = '{0, 7, 0, 7};
        e2 = '{1, 0, 1, 0};
        chk_seq("w8_grants", g8, e1);
        chk_seq("w8_ptrs", p8, e2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ppe_rr_pipe.md
# ppe_rr_pipe

Parametrised, pipelined programmable priority encoder with a built-in round-robin mode. It finds the first set bit of a W-bit request vector, searching upward from a start index and wrapping. The start index comes either from an input (programmable mode) or from an internal pointer that advances past each grant (round-robin mode). It sits where the fixed 512-bit registered encoder sits today, and adds valid/ready flow control, backpressure and arbitration-pointer state.

## Interface
- W, default 512: request width; power of two, at least 2.
- LW, default $clog2(W): index width; derived, never overridden.
- clk  input  1  single clock; all state on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  request beat offered.
- in_ready  output  1  block accepts a beat this cycle.
- Req  input  W  request vector; bit i set means requester i is requesting.
- P_enc  input  LW  search start index; used only when rr_mode=0.
- rr_mode  input  1  1 = use the internal pointer; sampled per beat with Req.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- o_value  output  LW  granted index.
- found  output  1  1 if Req had any set bit.
- rr_ptr  output  LW  current internal pointer (observability).

## Operation
- Encode rule:
  - with start index S, grant = the lowest set index i ≥ S;
  - if none exists, grant = the lowest set index overall (wrap);
  - if Req = 0: found = 0, o_value = 0.
- Stage S1 holds {Req, P_enc, rr_mode} and s1_valid.
- Stage S2 holds {o_value, found} and out_valid.
- Start index: S = rr_mode ? rr_ptr : P_enc, evaluated combinationally from the S1 contents at the moment S1 transfers to S2. It is not captured at input time, so back-to-back round-robin beats each see the updated pointer.
- Flow control:
  - s2_adv = s1_valid && (!out_valid || out_ready);
  - in_ready = !rst && (!s1_valid || s2_adv);
  - S1 loads when in_valid && in_ready;
  - S2 loads when s2_adv;
  - out_valid clears when out_ready && !s2_adv.
- Pointer update:
  - on s2_adv with rr_mode=1 and found=1, rr_ptr ← (grant + 1) mod W, so a grant at W−1 wraps the pointer to 0;
  - no pointer change in programmable mode or when found=0.
- While out_valid && !out_ready, o_value and found hold stable.
- No beat is dropped, duplicated or reordered.
- Reset (any cycle, including mid-transfer):
  - s1_valid = 0, out_valid = 0, o_value = 0, found = 0, rr_ptr = 0;
  - in-flight beats are discarded;
  - in_ready = 0 while rst = 1 and 1 on the first cycle after.

## Timing
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+1, i.e. two registers. This matches the existing encoder's in/out register pair.
- Throughput is one beat per cycle with out_ready held high.
- Backpressure ripples back one stage per cycle:
  - out_ready low with S2 full leaves S1 able to fill once;
  - in_ready then goes low in the same cycle S1 is full and S2 is blocked.
- Simultaneous S1 load and S2 load in the same cycle is normal pipelined operation.
- The encoder logic is combinational between S1 and S2, depth O(log W).
- rr_ptr changes only on an S2 load edge.

## Test plan
- Programmable mode, W=512:
  - Req bits {3, 100, 400}, P_enc = 101 → o_value = 400, found = 1, out_valid two cycles after acceptance;
  - P_enc = 400 → 400.
- Wrap: same Req with P_enc = 401 → o_value = 3. Req = 0 → found = 0, o_value = 0, rr_ptr unchanged.
- Round-robin, back-to-back: Req bits {5, 9, 511} held, rr_mode = 1, four consecutive beats with out_ready = 1:
  - grants are 5, 9, 511, 5;
  - rr_ptr sequence is 0 → 6 → 10 → 0 → 6.
- Backpressure:
  - stream beats P_enc = 0..5 on Req = all ones, with out_ready low for cycles 3–5;
  - in_ready drops once S1 fills;
  - o_value holds stable while stalled;
  - outputs emerge in order 0..5, none lost.
- Reset mid-operation:
  - assert rst with both stages full in round-robin mode → next cycle out_valid = 0, rr_ptr = 0, o_value = 0;
  - the first post-reset beat (Req bit 7 only) → grant 7.
- Second instance with W=8, LW=3: Req = 8'b1000_0001 with rr_mode = 1 → alternating grants 0, 7, 0, 7 with rr_ptr wrapping from 7+1 to 0.
